im_compress_sched: RTL and testbench

IM_COMPRESS_SCHED -- requirements
Module: im_compress_sched

---
 rtl/im_work_pkg.sv | 30 +++
 rtl/im_tile_addr_gen.sv | 71 +++++++
 rtl/im_compress_sched.sv | 137 +++++++++++++
 tb/tb_im_compress_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_work_pkg.sv
// Shared FSM state encoding, default image/tile geometry and address-width helpers
// for the tile compression scheduler.
package im_work_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_ADVANCE   = 3'd3,
        S_FRAME_END = 3'd4
    } state_t;

    localparam int DEF_IN_W    = 640;
    localparam int DEF_IN_H    = 480;
    localparam int DEF_AREA_W  = 4;
    localparam int DEF_AREA_H  = 4;
    localparam int DEF_TIMEOUT = 64;

    localparam int OUT_W = DEF_IN_W / DEF_AREA_W;
    localparam int OUT_H = DEF_IN_H / DEF_AREA_H;

    // Never return a zero width, even for degenerate one-entry ranges.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    localparam int PTR_W  = clog2_min1(DEF_IN_W * DEF_IN_H);
    localparam int ADDR_W = clog2_min1(OUT_W * OUT_H);

endpackage

// File: rtl/im_tile_addr_gen.sv
// Tile column/row counters with incremental input-pointer and output-address stepping.
// Row stepping adds a precomputed row stride to the saved row base, so no multiplier is built.
module im_tile_addr_gen
    import im_work_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int IN_H   = DEF_IN_H,
    parameter int AREA_W = DEF_AREA_W,
    parameter int AREA_H = DEF_AREA_H,
    parameter int P_W    = PTR_W,
    parameter int A_W    = ADDR_W
) (
    input  logic           iclk,
    input  logic           irst,
    input  logic           i_clear,
    input  logic           i_step,
    output logic [P_W-1:0] o_ptr,
    output logic [A_W-1:0] o_addr,
    output logic           o_last_tile
);

    localparam int TILES_X = IN_W / AREA_W;
    localparam int TILES_Y = IN_H / AREA_H;
    localparam int CW      = clog2_min1(TILES_X);
    localparam int RW      = clog2_min1(TILES_Y);

    localparam logic [P_W-1:0] COL_STEP = P_W'(AREA_W);
    localparam logic [P_W-1:0] ROW_STEP = P_W'(AREA_H * IN_W);
    localparam logic [CW-1:0]  LAST_COL = CW'(TILES_X - 1);
    localparam logic [RW-1:0]  LAST_ROW = RW'(TILES_Y - 1);

    logic [CW-1:0]  r_col;
    logic [RW-1:0]  r_row;
    logic [P_W-1:0] r_ptr;
    logic [P_W-1:0] r_row_base;
    logic [A_W-1:0] r_addr;
    logic           w_last_col;

    assign w_last_col  = (r_col == LAST_COL);
    assign o_last_tile = w_last_col && (r_row == LAST_ROW);
    assign o_ptr       = r_ptr;
    assign o_addr      = r_addr;

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_ptr      <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
        end else if (i_clear) begin
            r_col      <= '0;
            r_row      <= '0;
            r_ptr      <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
        end else if (i_step) begin
            r_addr <= r_addr + 1'b1;
            if (w_last_col) begin
                r_col      <= '0;
                r_row      <= r_row + 1'b1;
                r_row_base <= r_row_base + ROW_STEP;
                r_ptr      <= r_row_base + ROW_STEP;
            end else begin
                r_col <= r_col + 1'b1;
                r_ptr <= r_ptr + COL_STEP;
            end
        end
    end

endmodule

// File: rtl/im_compress_sched.sv
// Frame scheduler: walks the image tile by tile, kicks the compression engine and writes one
// output pixel per tile. Optional watchdog built only with IM_COMPRESS_SCHED_TIMEOUT_EN.
//   state     | meaning
//   IDLE      | waiting for iframe_start
//   ISSUE     | ostart_work pulse for the current tile
//   WAIT_DONE | waiting for the engine (or the watchdog)
//   ADVANCE   | write strobe out, step to next tile
//   FRAME_END | oframe_done pulse, back to IDLE
module im_compress_sched
    import im_work_pkg::*;
#(
    parameter int pIN_IM_WIDTH  = DEF_IN_W,
    parameter int pIN_IM_HEIGHT = DEF_IN_H,
    parameter int pAREA_WIDTH   = DEF_AREA_W,
    parameter int pAREA_HEIGHT  = DEF_AREA_H,
    parameter int pTIMEOUT      = DEF_TIMEOUT,
    localparam int P_W = clog2_min1(pIN_IM_WIDTH * pIN_IM_HEIGHT),
    localparam int A_W = clog2_min1((pIN_IM_WIDTH / pAREA_WIDTH) * (pIN_IM_HEIGHT / pAREA_HEIGHT))
) (
    input  logic           iclk,
    input  logic           irst,
    input  logic           iframe_start,
    output logic           obusy,
    output logic           oframe_done,
    output logic           ostart_work,
    output logic [P_W-1:0] odata_start_ptr,
    input  logic           iengine_done_f,
    output logic           owr_en,
    output logic [A_W-1:0] oaddr_wr,
    output logic           oerr
);

    if (((pIN_IM_WIDTH % pAREA_WIDTH) != 0) || ((pIN_IM_HEIGHT % pAREA_HEIGHT) != 0)) begin : g_bad_dims
        $error("im_compress_sched: image dimensions must be multiples of the tile dimensions");
    end

    state_t r_state;
    state_t w_next;
    logic   w_accept;
    logic   w_clear;
    logic   w_step;
    logic   w_last_tile;
    logic   w_timeout;
    logic   r_wr_en;

    im_tile_addr_gen #(
        .IN_W   (pIN_IM_WIDTH),
        .IN_H   (pIN_IM_HEIGHT),
        .AREA_W (pAREA_WIDTH),
        .AREA_H (pAREA_HEIGHT),
        .P_W    (P_W),
        .A_W    (A_W)
    ) u_addr_gen (
        .iclk        (iclk),
        .irst        (irst),
        .i_clear     (w_clear),
        .i_step      (w_step),
        .o_ptr       (odata_start_ptr),
        .o_addr      (oaddr_wr),
        .o_last_tile (w_last_tile)
    );

`ifdef IM_COMPRESS_SCHED_TIMEOUT_EN
    localparam int TW = clog2_min1(pTIMEOUT);

    logic [TW-1:0] r_wd;
    logic          r_err;

    // Engine completion in the terminal cycle still wins over the timeout.
    assign w_timeout = (r_state == S_WAIT_DONE) && !iengine_done_f && (r_wd == '0);
    assign oerr      = r_err;

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_ISSUE)
                r_wd <= TW'(pTIMEOUT - 1);
            else if ((r_state == S_WAIT_DONE) && (r_wd != '0))
                r_wd <= r_wd - 1'b1;

            if (w_accept)
                r_err <= 1'b0;
            else if (w_timeout)
                r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign oerr      = 1'b0;
`endif

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_state <= S_IDLE;
            r_wr_en <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wr_en <= (r_state == S_WAIT_DONE) && iengine_done_f;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_clear  = 1'b0;
        w_step   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iframe_start) begin
                    w_accept = 1'b1;
                    w_clear  = 1'b1;
                    w_next   = S_ISSUE;
                end
            end
            S_ISSUE:     w_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (iengine_done_f || w_timeout)
                    w_next = S_ADVANCE;
            end
            S_ADVANCE: begin
                // Hold the final tile position rather than stepping past the frame.
                w_step = !w_last_tile;
                w_next = w_last_tile ? S_FRAME_END : S_ISSUE;
            end
            S_FRAME_END: w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    assign obusy       = (r_state != S_IDLE);
    assign ostart_work = (r_state == S_ISSUE);
    assign oframe_done = (r_state == S_FRAME_END);
    assign owr_en      = r_wr_en;

endmodule

// File: tb/tb_im_compress_sched.sv
// Directed bench: 8x8/4x4 instance for sequencing, reset and watchdog cases, plus a default
// 640x480 instance for the full-frame run.
module tb_im_compress_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- instance A: 8x8 image, 4x4 tiles ----------------
    logic       rst_a = 1'b1, fs_a = 1'b0;
    logic       busy_a, fd_a, sw_a, wr_a, err_a, done_a;
    logic [5:0] ptr_a;
    logic [1:0] addr_a;

    im_compress_sched #(
        .pIN_IM_WIDTH(8), .pIN_IM_HEIGHT(8), .pAREA_WIDTH(4), .pAREA_HEIGHT(4), .pTIMEOUT(8)
    ) u_dut_a (
        .iclk(clk), .irst(rst_a), .iframe_start(fs_a), .obusy(busy_a), .oframe_done(fd_a),
        .ostart_work(sw_a), .odata_start_ptr(ptr_a), .iengine_done_f(done_a), .owr_en(wr_a),
        .oaddr_wr(addr_a), .oerr(err_a)
    );

    int   eng_delay = 5;
    int   withhold_idx = -1;
    int   eng_cnt = 0;
    logic eng_done = 1'b0;
    logic stray = 1'b0;
    assign done_a = eng_done | stray;

    always @(negedge clk) begin
        eng_done = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) eng_done = 1'b1;
        end
        if (sw_a && (int'(addr_a) != withhold_idx)) eng_cnt = eng_delay;
    end

    int st_ptr [64];
    int st_cyc [64];
    int wr_addr[64];
    int n_start_a = 0, n_wr_a = 0, n_fd_a = 0, n_unstable = 0, n_err_seen = 0;
    int held_ptr = 0;

    always @(negedge clk) begin
        if (sw_a) begin
            if (n_start_a < 64) begin
                st_ptr[n_start_a] = int'(ptr_a);
                st_cyc[n_start_a] = cyc;
            end
            held_ptr = int'(ptr_a);
            n_start_a++;
        end
        if (wr_a) begin
            if (n_wr_a < 64) wr_addr[n_wr_a] = int'(addr_a);
            if (int'(ptr_a) != held_ptr) n_unstable++;
            n_wr_a++;
        end
        if (fd_a) n_fd_a++;
        if (err_a) n_err_seen++;
    end

    // ---------------- instance B: default 640x480 ----------------
    logic        rst_b = 1'b1, fs_b = 1'b0;
    logic        busy_b, fd_b, sw_b, wr_b, err_b;
    logic        done_b = 1'b0;
    logic [18:0] ptr_b;
    logic [14:0] addr_b;

    im_compress_sched u_dut_b (
        .iclk(clk), .irst(rst_b), .iframe_start(fs_b), .obusy(busy_b), .oframe_done(fd_b),
        .ostart_work(sw_b), .odata_start_ptr(ptr_b), .iengine_done_f(done_b), .owr_en(wr_b),
        .oaddr_wr(addr_b), .oerr(err_b)
    );

    logic pend_b = 1'b0;
    int   n_wr_b = 0, n_fd_b = 0, last_ptr_b = -1, last_addr_b = -1;

    always @(negedge clk) begin
        done_b = pend_b;
        pend_b = sw_b;
        if (sw_b) last_ptr_b = int'(ptr_b);
        if (wr_b) begin
            n_wr_b++;
            last_addr_b = int'(addr_b);
        end
        if (fd_b) n_fd_b++;
    end

    // Step to just after a falling edge so monitors have settled.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        fs_a = 1'b1;
        tick(1);
        fs_a = 1'b0;
    endtask

    task automatic wait_frame_a(input int fbase, input string name);
        int k = 0;
        while ((n_fd_a == fbase) && (k < 400)) begin
            tick(1);
            k++;
        end
        n_checks++;
        if (k >= 400) $display("FAIL %s_timeout: frame_done not seen after %0d cycles", name, k);
        else n_pass++;
    endtask

    task automatic test_reset();
        tick(3);
        n_checks++; if (busy_a !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_a); else n_pass++;
        n_checks++; if (fd_a !== 1'b0) $display("FAIL rst_frame_done: got %b want 0", fd_a); else n_pass++;
        n_checks++; if (sw_a !== 1'b0) $display("FAIL rst_start: got %b want 0", sw_a); else n_pass++;
        n_checks++; if (wr_a !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", wr_a); else n_pass++;
        n_checks++; if (ptr_a !== 6'd0) $display("FAIL rst_ptr: got %0d want 0", ptr_a); else n_pass++;
        n_checks++; if (addr_a !== 2'd0) $display("FAIL rst_addr: got %0d want 0", addr_a); else n_pass++;
        n_checks++; if (err_a !== 1'b0) $display("FAIL rst_err: got %b want 0", err_a); else n_pass++;
        n_checks++; if (busy_b !== 1'b0) $display("FAIL rst_busy_b: got %b want 0", busy_b); else n_pass++;
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick(2);
    endtask

    task automatic test_frame();
        int exp_ptr[4] = '{0, 4, 32, 36};
        int sbase = n_start_a, wbase = n_wr_a, fbase = n_fd_a, ubase = n_unstable;
        pulse_start_a();
        n_checks++; if (busy_a !== 1'b1) $display("FAIL frame_busy: got %b want 1", busy_a); else n_pass++;
        n_checks++; if (sw_a !== 1'b1) $display("FAIL frame_first_start: got %b want 1", sw_a); else n_pass++;
        wait_frame_a(fbase, "frame");
        tick(3);
        n_checks++; if (n_start_a - sbase != 4) $display("FAIL frame_starts: got %0d want 4", n_start_a - sbase); else n_pass++;
        n_checks++; if (n_wr_a - wbase != 4) $display("FAIL frame_writes: got %0d want 4", n_wr_a - wbase); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (st_ptr[sbase+i] != exp_ptr[i]) $display("FAIL frame_ptr%0d: got %0d want %0d", i, st_ptr[sbase+i], exp_ptr[i]);
            else n_pass++;
            n_checks++;
            if (wr_addr[wbase+i] != i) $display("FAIL frame_addr%0d: got %0d want %0d", i, wr_addr[wbase+i], i);
            else n_pass++;
        end
        n_checks++; if (st_cyc[sbase+1] - st_cyc[sbase] != 7) $display("FAIL frame_tile_period: got %0d want 7", st_cyc[sbase+1] - st_cyc[sbase]); else n_pass++;
        n_checks++; if (n_unstable != ubase) $display("FAIL frame_ptr_stable: got %0d unstable want 0", n_unstable - ubase); else n_pass++;
        n_checks++; if (n_fd_a - fbase != 1) $display("FAIL frame_done_count: got %0d want 1", n_fd_a - fbase); else n_pass++;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL frame_busy_end: got %b want 0", busy_a); else n_pass++;
    endtask

    task automatic test_busy_restart();
        int sbase = n_start_a, wbase = n_wr_a, fbase = n_fd_a, k = 0;
        pulse_start_a();
        tick(10);
        pulse_start_a();
        while (!fd_a && (k < 400)) begin
            tick(1);
            k++;
        end
        n_checks++; if (k >= 400) $display("FAIL busy_timeout: frame_done not seen after %0d cycles", k); else n_pass++;
        // Request coincides with FRAME_END and must be dropped.
        pulse_start_a();
        tick(20);
        n_checks++; if (n_start_a - sbase != 4) $display("FAIL busy_starts: got %0d want 4", n_start_a - sbase); else n_pass++;
        n_checks++; if (n_wr_a - wbase != 4) $display("FAIL busy_writes: got %0d want 4", n_wr_a - wbase); else n_pass++;
        n_checks++; if (n_fd_a - fbase != 1) $display("FAIL busy_done_count: got %0d want 1", n_fd_a - fbase); else n_pass++;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL busy_after_coincide: got %b want 0", busy_a); else n_pass++;
    endtask

    task automatic test_stray_done();
        int sbase = n_start_a, wbase = n_wr_a;
        stray = 1'b1;
        tick(1);
        stray = 1'b0;
        tick(4);
        n_checks++; if (n_wr_a != wbase) $display("FAIL stray_writes: got %0d want 0", n_wr_a - wbase); else n_pass++;
        n_checks++; if (n_start_a != sbase) $display("FAIL stray_starts: got %0d want 0", n_start_a - sbase); else n_pass++;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL stray_busy: got %b want 0", busy_a); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int sbase = n_start_a, wbase = n_wr_a, fbase = n_fd_a, k = 0;
        pulse_start_a();
        while ((n_start_a - sbase < 2) && (k < 200)) begin
            tick(1);
            k++;
        end
        n_checks++; if (k >= 200) $display("FAIL rmid_timeout: second start not seen after %0d cycles", k); else n_pass++;
        rst_a = 1'b1;
        #1;
        n_checks++; if (sw_a !== 1'b0) $display("FAIL rmid_start: got %b want 0", sw_a); else n_pass++;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy_a); else n_pass++;
        n_checks++; if (ptr_a !== 6'd0) $display("FAIL rmid_ptr: got %0d want 0", ptr_a); else n_pass++;
        n_checks++; if (addr_a !== 2'd0) $display("FAIL rmid_addr: got %0d want 0", addr_a); else n_pass++;
        tick(2);
        rst_a = 1'b0;
        tick(30);
        n_checks++; if (n_fd_a != fbase) $display("FAIL rmid_frame_done: got %0d want 0", n_fd_a - fbase); else n_pass++;
        n_checks++; if (n_wr_a - wbase != 1) $display("FAIL rmid_writes: got %0d want 1", n_wr_a - wbase); else n_pass++;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL rmid_busy_after: got %b want 0", busy_a); else n_pass++;
    endtask

`ifdef IM_COMPRESS_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int exp_addr[3] = '{0, 2, 3};
        int sbase = n_start_a, wbase = n_wr_a, fbase = n_fd_a;
        withhold_idx = 1;
        pulse_start_a();
        wait_frame_a(fbase, "wdog");
        tick(2);
        withhold_idx = -1;
        n_checks++; if (err_a !== 1'b1) $display("FAIL wdog_err_set: got %b want 1", err_a); else n_pass++;
        n_checks++; if (n_start_a - sbase != 4) $display("FAIL wdog_starts: got %0d want 4", n_start_a - sbase); else n_pass++;
        n_checks++; if (n_wr_a - wbase != 3) $display("FAIL wdog_writes: got %0d want 3", n_wr_a - wbase); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (wr_addr[wbase+i] != exp_addr[i]) $display("FAIL wdog_addr%0d: got %0d want %0d", i, wr_addr[wbase+i], exp_addr[i]);
            else n_pass++;
        end
        n_checks++; if (n_fd_a - fbase != 1) $display("FAIL wdog_done_count: got %0d want 1", n_fd_a - fbase); else n_pass++;
        fbase = n_fd_a;
        pulse_start_a();
        n_checks++; if (err_a !== 1'b0) $display("FAIL wdog_err_clear: got %b want 0", err_a); else n_pass++;
        wait_frame_a(fbase, "wdog2");
        tick(2);
        n_checks++; if (err_a !== 1'b0) $display("FAIL wdog_err_clean_frame: got %b want 0", err_a); else n_pass++;
    endtask
`else
    task automatic test_no_timeout();
        n_checks++; if (n_err_seen != 0) $display("FAIL noto_err_seen: got %0d cycles want 0", n_err_seen); else n_pass++;
        n_checks++; if (err_b !== 1'b0) $display("FAIL noto_err_b: got %b want 0", err_b); else n_pass++;
    endtask
`endif

    task automatic test_big_frame();
        int k = 0;
        fs_b = 1'b1;
        tick(1);
        fs_b = 1'b0;
        while ((n_fd_b == 0) && (k < 70000)) begin
            tick(1);
            k++;
        end
        n_checks++; if (k >= 70000) $display("FAIL big_timeout: frame_done not seen after %0d cycles", k); else n_pass++;
        tick(3);
        n_checks++; if (n_wr_b != 19200) $display("FAIL big_writes: got %0d want 19200", n_wr_b); else n_pass++;
        n_checks++; if (last_ptr_b != 636 + 476 * 640) $display("FAIL big_last_ptr: got %0d want %0d", last_ptr_b, 636 + 476 * 640); else n_pass++;
        n_checks++; if (last_addr_b != 19199) $display("FAIL big_last_addr: got %0d want 19199", last_addr_b); else n_pass++;
        n_checks++; if (n_fd_b != 1) $display("FAIL big_done_count: got %0d want 1", n_fd_b); else n_pass++;
        n_checks++; if (busy_b !== 1'b0) $display("FAIL big_busy_end: got %b want 0", busy_b); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_busy_restart();
        test_stray_done();
        test_reset_mid();
`ifdef IM_COMPRESS_SCHED_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_big_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
